// File: rtl/lsu_align_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_align_ctrl
//
// Load/store alignment controller. It accepts one scalar memory access at a
// time and turns it into one or two word-aligned bus beats. For stores it
// places the data on the correct byte lanes. For loads it merges the returned
// beats, realigns the bytes and sign- or zero-extends the result.
//
// An access whose bytes spill into the next bus word is normally reported as
// misaligned, and no bus traffic is generated. If the macro
// LSU_MISALIGNED_SPLIT_EN is defined, such an access is executed as two
// sequential beats instead. A dword access on a 32-bit datapath is always
// reported as misaligned.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_req / o_ready       access handshake; a request is taken only in IDLE
//   i_is_store            1 = store, 0 = load
//   i_funct3              [1:0] size (byte/half/word/dword), [2] zero-extend
//   i_addr, i_wdata       byte address, LSB-justified store data
//   o_dmem_*              bus beat: req, we, aligned addr, lane mask, data
//   i_dmem_ack/_rdata     beat completion with read data in the same cycle
//   o_done                one-cycle completion pulse
//   o_rdata               aligned, extended load result (valid with o_done)
//   o_misaligned          misalignment trap flag (valid with o_done)
// -----------------------------------------------------------------------------
module lsu_align_ctrl #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_req,
    output logic                o_ready,
    input  logic                i_is_store,
    input  logic [2:0]          i_funct3,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [XLEN-1:0]     i_wdata,
    output logic                o_dmem_req,
    output logic                o_dmem_we,
    output logic [ADDR_W-1:0]   o_dmem_addr,
    output logic [XLEN/8-1:0]   o_dmem_mask,
    output logic [XLEN-1:0]     o_dmem_wdata,
    input  logic                i_dmem_ack,
    input  logic [XLEN-1:0]     i_dmem_rdata,
    output logic                o_done,
    output logic [XLEN-1:0]     o_rdata,
    output logic                o_misaligned
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int MW    = 2 * NB;

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_t;

    state_t              state_reg, state_next;
    logic [2:0]          funct3_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [XLEN-1:0]     wdata_reg;
    logic                is_store_reg;
    logic                trap_reg;
    logic [XLEN-1:0]     rdata0_reg;
    logic [XLEN-1:0]     rdata1_reg;

    logic                accept;
    logic                cap0;
    logic                cap1;

    // Byte-lane mask over two consecutive bus words: low half is beat 0,
    // high half is beat 1.
    function automatic logic [MW-1:0] calc_mask(input logic [1:0] size,
                                                input logic [OFF_W-1:0] off);
        logic [MW-1:0] base;
        case (size)
            2'b00:   base = MW'(1);
            2'b01:   base = MW'(3);
            2'b10:   base = MW'(15);
            default: base = MW'(255);
        endcase
        return base << off;
    endfunction

    // Trap decision is made on the incoming request, so a trapping access
    // goes straight to RESP without touching the bus.
    logic [MW-1:0] req_mask;
    logic          req_illegal;
    logic          req_trap;

    assign req_mask    = calc_mask(i_funct3[1:0], i_addr[OFF_W-1:0]);
    assign req_illegal = (XLEN == 32) && (i_funct3[1:0] == 2'b11);
    assign req_trap    = req_illegal || ((|req_mask[MW-1:NB]) && !SPLIT_EN);

    // Registered-access derived values.
    logic [MW-1:0]     cur_mask;
    logic [2*XLEN-1:0] wshift;
    logic [ADDR_W-1:0] aligned_addr;

    assign cur_mask     = calc_mask(funct3_reg[1:0], addr_reg[OFF_W-1:0]);
    assign wshift       = {{XLEN{1'b0}}, wdata_reg} << {addr_reg[OFF_W-1:0], 3'b000};
    assign aligned_addr = {addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Load realignment: shift the two-word window down by the byte offset,
    // then keep N bytes and fill the rest with the extension bit.
    logic [2*XLEN-1:0] rshift;
    logic [3:0]        n_bytes;
    logic              sign_bit;
    logic              fill_bit;
    logic [XLEN-1:0]   load_result;

    assign rshift   = {rdata1_reg, rdata0_reg} >> {addr_reg[OFF_W-1:0], 3'b000};
    assign n_bytes  = 4'd1 << funct3_reg[1:0];
    assign fill_bit = sign_bit & ~funct3_reg[2];

    always_comb begin
        sign_bit = 1'b0;
        case (funct3_reg[1:0])
            2'b00:   sign_bit = rshift[7];
            2'b01:   sign_bit = rshift[15];
            2'b10:   sign_bit = rshift[31];
            default: sign_bit = rshift[XLEN-1];
        endcase
    end

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign load_result[8*gi +: 8] = (4'(gi) < n_bytes) ? rshift[8*gi +: 8]
                                                                : {8{fill_bit}};
        end
    endgenerate

    // Next-state and output logic.
    always_comb begin
        state_next   = state_reg;
        o_ready      = 1'b0;
        o_dmem_req   = 1'b0;
        o_dmem_we    = 1'b0;
        o_dmem_addr  = '0;
        o_dmem_mask  = '0;
        o_dmem_wdata = '0;
        o_done       = 1'b0;
        o_misaligned = 1'b0;
        o_rdata      = '0;
        accept       = 1'b0;
        cap0         = 1'b0;
        cap1         = 1'b0;
        case (state_reg)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_req) begin
                    accept     = 1'b1;
                    state_next = req_trap ? S_RESP : S_BEAT0;
                end
            end
            S_BEAT0: begin
                o_dmem_req   = 1'b1;
                o_dmem_we    = is_store_reg;
                o_dmem_addr  = aligned_addr;
                o_dmem_mask  = cur_mask[NB-1:0];
                o_dmem_wdata = wshift[XLEN-1:0];
                if (i_dmem_ack) begin
                    cap0       = 1'b1;
                    state_next = (|cur_mask[MW-1:NB]) ? S_BEAT1 : S_RESP;
                end
            end
            S_BEAT1: begin
                o_dmem_req   = 1'b1;
                o_dmem_we    = is_store_reg;
                o_dmem_addr  = aligned_addr + ADDR_W'(NB);
                o_dmem_mask  = cur_mask[MW-1:NB];
                o_dmem_wdata = wshift[2*XLEN-1:XLEN];
                if (i_dmem_ack) begin
                    cap1       = 1'b1;
                    state_next = S_RESP;
                end
            end
            default: begin
                o_done       = 1'b1;
                o_misaligned = trap_reg;
                o_rdata      = (trap_reg || is_store_reg) ? '0 : load_result;
                state_next   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= S_IDLE;
            funct3_reg   <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            is_store_reg <= 1'b0;
            trap_reg     <= 1'b0;
            rdata0_reg   <= '0;
            rdata1_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                funct3_reg   <= i_funct3;
                addr_reg     <= i_addr;
                wdata_reg    <= i_wdata;
                is_store_reg <= i_is_store;
                trap_reg     <= req_trap;
                rdata0_reg   <= '0;
                rdata1_reg   <= '0;
            end
            if (cap0) begin
                rdata0_reg <= i_dmem_rdata;
            end
            if (cap1) begin
                rdata1_reg <= i_dmem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_align_ctrl
//
// Self-checking bench for lsu_align_ctrl (XLEN=32). Expected bus beats and
// load results come from an arithmetic model of the access rules: lane mask,
// byte shift, merge, truncate and extend. Honours LSU_MISALIGNED_SPLIT_EN in
// the same way as the design.
// -----------------------------------------------------------------------------
module tb_lsu_align_ctrl;
    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic              i_clk;
    logic              i_rst_n;
    logic              i_req;
    logic              o_ready;
    logic              i_is_store;
    logic [2:0]        i_funct3;
    logic [ADDR_W-1:0] i_addr;
    logic [XLEN-1:0]   i_wdata;
    logic              o_dmem_req;
    logic              o_dmem_we;
    logic [ADDR_W-1:0] o_dmem_addr;
    logic [3:0]        o_dmem_mask;
    logic [XLEN-1:0]   o_dmem_wdata;
    logic              i_dmem_ack;
    logic [XLEN-1:0]   i_dmem_rdata;
    logic              o_done;
    logic [XLEN-1:0]   o_rdata;
    logic              o_misaligned;

    int tests_run = 0;
    int tests_failed = 0;

    lsu_align_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req        (i_req),
        .o_ready      (o_ready),
        .i_is_store   (i_is_store),
        .i_funct3     (i_funct3),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_we    (o_dmem_we),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_mask  (o_dmem_mask),
        .o_dmem_wdata (o_dmem_wdata),
        .i_dmem_ack   (i_dmem_ack),
        .i_dmem_rdata (i_dmem_rdata),
        .o_done       (o_done),
        .o_rdata      (o_rdata),
        .o_misaligned (o_misaligned)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // One complete access: drive the request, play the bus slave with the
    // given ack delay, and compare every beat and the response with the model.
    // With busy=1 the bench keeps i_req high (with junk fields) while the
    // access is in flight, which the design must ignore.
    task automatic run_access(input string name, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] r0, input logic [31:0] r1,
                              input int dly, input logic busy);
        int          n, off, nbeats;
        logic [7:0]  m;
        logic [63:0] ws, merged, val, keep;
        logic        trap;
        logic [31:0] exp_rdata, eaddr, ewd;
        logic [3:0]  emask;
        logic [70:0] exp_bus, got_bus;

        n      = 1 << f3[1:0];
        off    = int'(addr % 4);
        m      = 8'(((64'd1 << n) - 64'd1) << off);
        trap   = (f3[1:0] == 2'b11) || ((m[7:4] != 4'd0) && !SPLIT);
        nbeats = trap ? 0 : ((m[7:4] != 4'd0) ? 2 : 1);
        ws     = {32'd0, wd} << (8 * off);
        merged = {r1, r0};
        keep   = (64'd1 << (8 * n)) - 64'd1;
        val    = (merged >> (8 * off)) & keep;
        if (!f3[2] && val[8*n-1]) val = val | ~keep;
        exp_rdata = (trap || st) ? 32'd0 : val[31:0];

        tests_run++;
        if (o_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s ready_before_accept: got %b want 1", name, o_ready);
        end
        i_req = 1'b1; i_is_store = st; i_funct3 = f3; i_addr = addr; i_wdata = wd;
        @(posedge i_clk); #1;
        if (busy) begin
            i_is_store = 1'($urandom); i_funct3 = 3'($urandom);
            i_addr = $urandom; i_wdata = $urandom;
        end else begin
            i_req = 1'b0;
        end

        for (int b = 0; b < nbeats; b++) begin
            eaddr   = (addr & 32'hFFFF_FFFC) + 32'(4 * b);
            emask   = (b == 0) ? m[3:0] : m[7:4];
            ewd     = (b == 0) ? ws[31:0] : ws[63:32];
            exp_bus = {1'b1, st, eaddr, emask, ewd, 1'b0};
            for (int c = 0; c <= dly; c++) begin
                got_bus = {o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_mask, o_dmem_wdata, o_done};
                tests_run++;
                if (got_bus !== exp_bus) begin
                    tests_failed++;
                    $display("FAIL %s beat%0d_bus(req,we,addr,mask,wdata,done) cyc%0d: got %h want %h",
                             name, b, c, got_bus, exp_bus);
                end
                if (c < dly) begin
                    i_dmem_rdata = $urandom;
                    @(posedge i_clk); #1;
                end
            end
            i_dmem_ack = 1'b1;
            i_dmem_rdata = (b == 0) ? r0 : r1;
            @(posedge i_clk); #1;
            i_dmem_ack = 1'b0;
            i_dmem_rdata = $urandom;
        end

        i_req = 1'b0;
        tests_run++;
        if ({o_done, o_misaligned, o_rdata, o_dmem_req, o_ready} !== {1'b1, trap, exp_rdata, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL %s resp(done,mis,rdata,req,ready): got %b %b %h %b %b want 1 %b %h 0 0",
                     name, o_done, o_misaligned, o_rdata, o_dmem_req, o_ready, trap, exp_rdata);
        end
        @(posedge i_clk); #1;
        tests_run++;
        if ({o_done, o_ready, o_dmem_req} !== 3'b010) begin
            tests_failed++;
            $display("FAIL %s after_resp(done,ready,req): got %b%b%b want 010",
                     name, o_done, o_ready, o_dmem_req);
        end
        $display("[TB] %s st=%0d f3=%0d addr=%h wdata=%h beats=%0d -> rdata=%h mis=%0d",
                 name, st, f3, addr, wd, nbeats, exp_rdata, trap);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_req = 1'b0; i_is_store = 1'b0; i_funct3 = '0;
        i_addr = '0; i_wdata = '0; i_dmem_ack = 1'b0; i_dmem_rdata = '0;
        repeat (3) @(posedge i_clk);
        #1;
        tests_run++;
        if ({o_ready, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_mask, o_dmem_wdata,
             o_done, o_rdata, o_misaligned} !== {1'b1, 104'd0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: ready=%b req=%b we=%b addr=%h mask=%h wdata=%h done=%b rdata=%h mis=%b want ready=1 rest 0",
                     o_ready, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_mask, o_dmem_wdata,
                     o_done, o_rdata, o_misaligned);
        end
        i_rst_n = 1'b1;
        $display("[TB] reset released");
    endtask

    task automatic test_store_byte();
        run_access("sb_1003", 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 32'h0, 0, 1'b0);
        run_access("sh_2002", 1'b1, 3'b001, 32'h0000_2002, 32'h1234_5678, 32'h0, 32'h0, 1, 1'b0);
    endtask

    task automatic test_load_extend();
        run_access("lh_2002", 1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_0000, 32'h0, 0, 1'b0);
        run_access("lbu_4001", 1'b0, 3'b100, 32'h0000_4001, 32'h0, 32'h0000_F000, 32'h0, 0, 1'b0);
        run_access("lb_4001", 1'b0, 3'b000, 32'h0000_4001, 32'h0, 32'h0000_F000, 32'h0, 2, 1'b0);
        run_access("lhu_2002", 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_0000, 32'h0, 0, 1'b0);
    endtask

    task automatic test_misaligned();
        run_access("lw_3002", 1'b0, 3'b010, 32'h0000_3002, 32'h0, 32'hBBBB_AAAA, 32'h0000_CCCC, 1, 1'b0);
        run_access("sw_wrap", 1'b1, 3'b010, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 1'b0);
        run_access("lh_3003", 1'b0, 3'b001, 32'h0000_3003, 32'h0, 32'h80AA_AAAA, 32'h1111_11FF, 0, 1'b0);
        run_access("ld_illegal", 1'b0, 3'b011, 32'h0000_0010, 32'h0, 32'h1234_5678, 32'h0, 0, 1'b0);
    endtask

    task automatic test_req_ignored();
        run_access("busy_lw", 1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 32'h0, 2, 1'b1);
        run_access("busy_trap", 1'b1, 3'b011, 32'h0000_0044, 32'h5555_AAAA, 32'h0, 32'h0, 0, 1'b1);
    endtask

    task automatic test_reset_in_flight();
        i_req = 1'b1; i_is_store = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0000_0100;
        i_wdata = '0; i_dmem_ack = 1'b0;
        @(posedge i_clk); #1;
        i_req = 1'b0;
        tests_run++;
        if (o_dmem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_inflight_beat0_req: got %b want 1", o_dmem_req);
        end
        i_rst_n = 1'b0;
        #1;
        tests_run++;
        if ({o_dmem_req, o_ready, o_done} !== 3'b010) begin
            tests_failed++;
            $display("FAIL rst_inflight_immediate(req,ready,done): got %b%b%b want 010",
                     o_dmem_req, o_ready, o_done);
        end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        tests_run++;
        if ({o_done, o_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL rst_inflight_no_done(done,ready): got %b%b want 01", o_done, o_ready);
        end
        $display("[TB] reset during BEAT0 applied and released");
        run_access("post_rst_lw", 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h89AB_CDEF, 32'h0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_access("b2b_sb0", 1'b1, 3'b000, 32'h0000_0500, 32'h0000_0011, 32'h0, 32'h0, 0, 1'b0);
        run_access("b2b_lb1", 1'b0, 3'b000, 32'h0000_0501, 32'h0, 32'h0000_8000, 32'h0, 0, 1'b0);
        run_access("b2b_lw2", 1'b0, 3'b110, 32'h0000_0504, 32'h0, 32'hF00D_1234, 32'h0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [2:0] f3;
        for (int i = 0; i < 60; i++) begin
            f3 = {1'($urandom), 2'($urandom_range(3, 0))};
            run_access("rand", 1'($urandom), f3, $urandom, $urandom, $urandom, $urandom,
                       int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)));
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_extend();
        test_misaligned();
        test_req_ignored();
        test_reset_in_flight();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
